// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, access-size codes and
// the address-alignment helpers used by the request path.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Size code 3 behaves exactly like a word access.
    function automatic lsu_size_e decode_size(input logic [1:0] code);
        case (code)
            2'd0:    return SZ_B;
            2'd1:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input lsu_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return lo;
            SZ_H:    return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store strobe/replication and load lane
// extraction with sign/zero extension.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  lsu_size_e   size,
    input  logic [1:0]  lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  writeb,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte       = rdata[{lo, 3'b000} +: 8];
        rhalf       = lo[1] ? rdata[31:16] : rdata[15:0];
        writeb      = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rdata;
        case (size)
            SZ_B: begin
                writeb      = 4'b0001 << lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{~is_unsigned & rbyte[7]}}, rbyte};
            end
            SZ_H: begin
                writeb      = lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{~is_unsigned & rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and dmem. Define LSU_MISALIGN_FAULT_EN to
// fault misaligned half/word accesses instead of force-aligning them.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_fault,
    output logic          dmem_read,
    output logic [3:0]    dmem_writeb,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    input  logic [31:0]   dmem_rdata
);

    lsu_state_e  state, state_nxt;
    lsu_size_e   req_sz, cap_size, la_size;
    logic [1:0]  req_lo, cap_lo, la_lo;
    logic        cap_write, cap_unsigned;
    logic        accept, misaligned, fault_q;
    logic [3:0]  la_writeb;
    logic [31:0] la_wdata, la_rdata;
    logic        unused_addr_hi;

    assign req_sz         = decode_size(req_size);
    assign req_lo         = align_lo(req_sz, req_addr[1:0]);
    assign accept         = req_valid && req_ready;
    assign unused_addr_hi = ^req_addr[31:AW+2];

`ifdef LSU_MISALIGN_FAULT_EN
    assign misaligned = is_misaligned(req_sz, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_fault = fault_q;

    // The aligner serves the store path at accept and the load path afterwards.
    assign la_size = (state == ST_IDLE) ? req_sz : cap_size;
    assign la_lo   = (state == ST_IDLE) ? req_lo : cap_lo;

    lsu_lane_align u_align (
        .size        (la_size),
        .lo          (la_lo),
        .is_unsigned (cap_unsigned),
        .wdata       (req_wdata),
        .rdata       (dmem_rdata),
        .writeb      (la_writeb),
        .wdata_lanes (la_wdata),
        .rdata_ext   (la_rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = misaligned ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = cap_write ? ST_RESP : ST_WAIT;
            ST_WAIT:  state_nxt = ST_RESP;
            ST_RESP:  if (resp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cap_write    <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_size     <= SZ_B;
            cap_lo       <= '0;
            fault_q      <= 1'b0;
            resp_rdata   <= '0;
            dmem_read    <= 1'b0;
            dmem_writeb  <= '0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
        end else begin
            state       <= state_nxt;
            dmem_read   <= 1'b0;
            dmem_writeb <= '0;
            if (state == ST_IDLE && accept) begin
                cap_write    <= req_write;
                cap_unsigned <= req_unsigned;
                cap_size     <= req_sz;
                cap_lo       <= req_lo;
                fault_q      <= misaligned;
                resp_rdata   <= '0;
                if (!misaligned) begin
                    dmem_addr <= req_addr[AW+1:2];
                    if (req_write) begin
                        dmem_writeb <= la_writeb;
                        dmem_wdata  <= la_wdata;
                    end else begin
                        dmem_read <= 1'b1;
                    end
                end
            end
            if (state == ST_WAIT) resp_rdata <= la_rdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a one-cycle-latency
// dmem model that only returns valid data in the cycle after a read strobe.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        dmem_read;
    logic [3:0]  dmem_writeb;
    logic [10:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'hDEAD_BEEF;

    logic [31:0] mem_word = '0;
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [10:0] rd_addr = '0, wr_addr = '0;
    logic [3:0]  wr_b = '0;
    logic [31:0] wr_data = '0;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.AW(11)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .dmem_read    (dmem_read),
        .dmem_writeb  (dmem_writeb),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dmem_rdata <= dmem_read ? mem_word : 32'hDEAD_BEEF;
        if (dmem_read) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= dmem_addr;
        end
        if (dmem_writeb != 4'b0000) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= dmem_addr;
            wr_b    <= dmem_writeb;
            wr_data <= dmem_wdata;
        end
        if (dmem_read && dmem_writeb != 4'b0000) both_cnt <= both_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one request for a single cycle, then scrambles req_* and waits for resp_valid.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output int lat);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        step();
        lat = 1;
        req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_unsigned = ~uns;
        req_addr = ~a; req_wdata = ~wd;
        while (resp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic ack(input string tag);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, ".done_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, ".done_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] memw,
                            input logic [31:0] exp_data, input logic [10:0] exp_addr);
        int lat, rd0, wr0;
        mem_word = memw;
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b0, sz, uns, a, 32'h5555_5555, lat);
        check({tag, ".lat"}, lat, 32'd3);
        check({tag, ".rdata"}, resp_rdata, exp_data);
        check({tag, ".fault"}, {31'b0, resp_fault}, 32'd0);
        check({tag, ".reads"}, rd_cnt - rd0, 32'd1);
        check({tag, ".writes"}, wr_cnt - wr0, 32'd0);
        check({tag, ".addr"}, {21'b0, rd_addr}, {21'b0, exp_addr});
        ack(tag);
    endtask

    task automatic store_chk(input string tag, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] exp_b,
                             input logic [31:0] exp_wd, input logic [10:0] exp_addr);
        int lat, rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b1, sz, 1'b0, a, wd, lat);
        check({tag, ".lat"}, lat, 32'd2);
        check({tag, ".rdata"}, resp_rdata, 32'd0);
        check({tag, ".writes"}, wr_cnt - wr0, 32'd1);
        check({tag, ".reads"}, rd_cnt - rd0, 32'd0);
        check({tag, ".writeb"}, {28'b0, wr_b}, {28'b0, exp_b});
        check({tag, ".wdata"}, wr_data, exp_wd);
        check({tag, ".addr"}, {21'b0, wr_addr}, {21'b0, exp_addr});
        ack(tag);
    endtask

    initial begin
        int lat, rd0, wr0;
        logic seen;

        step(); step();
        rst = 1'b0;
        step();
        check("rst.req_ready", {31'b0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst.dmem_read", {31'b0, dmem_read}, 32'd0);
        check("rst.dmem_writeb", {28'b0, dmem_writeb}, 32'd0);
        check("rst.dmem_addr", {21'b0, dmem_addr}, 32'd0);
        check("rst.dmem_wdata", dmem_wdata, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_fault", {31'b0, resp_fault}, 32'd0);

        store_chk("sb6", 2'd0, 32'h0000_0006, 32'h1234_56A5, 4'b0100, 32'hA5A5_A5A5, 11'd1);
        store_chk("sh2", 2'd1, 32'h0000_0002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 11'd0);
        store_chk("sw8", 2'd2, 32'h0000_0008, 32'h1234_5678, 4'b1111, 32'h1234_5678, 11'd2);
        store_chk("sb1", 2'd0, 32'h0000_0011, 32'h0000_003C, 4'b0010, 32'h3C3C_3C3C, 11'd4);

        load_chk("lb7",  2'd0, 1'b0, 32'h0000_0007, 32'h8011_2233, 32'hFFFF_FF80, 11'd1);
        load_chk("lbu7", 2'd0, 1'b1, 32'h0000_0007, 32'h8011_2233, 32'h0000_0080, 11'd1);
        load_chk("lbu1", 2'd0, 1'b1, 32'h0000_0001, 32'h8011_2233, 32'h0000_0022, 11'd0);
        load_chk("lb0",  2'd0, 1'b0, 32'h0000_0000, 32'h8011_22B3, 32'hFFFF_FFB3, 11'd0);
        load_chk("lh2",  2'd1, 1'b0, 32'h0000_0002, 32'h8001_1234, 32'hFFFF_8001, 11'd0);
        load_chk("lhu2", 2'd1, 1'b1, 32'h0000_0002, 32'h8001_1234, 32'h0000_8001, 11'd0);
        load_chk("lh0",  2'd1, 1'b0, 32'h0000_0000, 32'h8001_1234, 32'h0000_1234, 11'd0);
        load_chk("lw4",  2'd2, 1'b0, 32'h0000_0004, 32'h8001_1234, 32'h8001_1234, 11'd1);
        load_chk("lsz3", 2'd3, 1'b0, 32'h0000_000C, 32'hF00D_CAFE, 32'hF00D_CAFE, 11'd3);

        // Wrapped address with response held off for five cycles.
        mem_word = 32'h8001_1234;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_2004, '0, lat);
        check("wrap.lat", lat, 32'd3);
        check("wrap.addr", {21'b0, rd_addr}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold.valid", {31'b0, resp_valid}, 32'd1);
            check("hold.rdata", resp_rdata, 32'h8001_1234);
        end
        ack("hold");

        // Misaligned word at address 3.
        mem_word = 32'hCAFE_F00D;
        rd0 = rd_cnt; wr0 = wr_cnt;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0003, '0, lat);
`ifdef LSU_MISALIGN_FAULT_EN
        check("mis.lat", lat, 32'd1);
        check("mis.fault", {31'b0, resp_fault}, 32'd1);
        check("mis.rdata", resp_rdata, 32'd0);
        check("mis.reads", rd_cnt - rd0, 32'd0);
`else
        check("mis.lat", lat, 32'd3);
        check("mis.fault", {31'b0, resp_fault}, 32'd0);
        check("mis.rdata", resp_rdata, 32'hCAFE_F00D);
        check("mis.reads", rd_cnt - rd0, 32'd1);
        check("mis.addr", {21'b0, rd_addr}, 32'd0);
`endif
        check("mis.writes", wr_cnt - wr0, 32'd0);
        ack("mis");

        // Reset while the load is in WAIT: the response must be dropped.
        mem_word = 32'h1111_2222;
        rd0 = rd_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0010;
        step();
        req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstw.req_ready", {31'b0, req_ready}, 32'd1);
        check("rstw.resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rstw.reads", rd_cnt - rd0, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        check("rstw.stale", {31'b0, seen}, 32'd0);
        load_chk("post", 2'd0, 1'b1, 32'h0000_0002, 32'h00A7_0000, 32'h0000_00A7, 11'd0);

        check("exclusive_strobes", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
